// File: rtl/pio_input_conditioner.sv
// rtl/pio_input_conditioner.sv - two-flop synchroniser plus shared-prescaler debounce for the input PIO
module pio_input_conditioner #(
    parameter int                 WIDTH        = 8,
    parameter int                 PRESCALE     = 500,
    parameter int                 STABLE_COUNT = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             enable,
    output logic [WIDTH-1:0] clean_out,
    output logic             change,
    output logic             sample_tick
);

    localparam int              PC_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int              CNT_W    = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] accept;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt [WIDTH];

    // Synchroniser runs regardless of enable so s2 is already settled on re-enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= RESET_VALUE;
            s2 <= RESET_VALUE;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    assign sample_tick = enable && (pc == PC_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
        end else if (!enable || (pc == PC_LAST)) begin
            pc <= '0;
        end else begin
            pc <= pc + 1'b1;
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = sample_tick && (s2[i] != clean_out[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // A matching sample, an acceptance or a disable all restart the bit's run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!enable || (sample_tick && ((s2[i] == clean_out[i]) || accept[i]))) begin
                    cnt[i] <= '0;
                end else if (sample_tick) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clean_out <= RESET_VALUE;
            change    <= 1'b0;
        end else begin
            clean_out <= (clean_out & ~accept) | (s2 & accept);
            change    <= |accept;
        end
    end

endmodule

// File: tb/tb_pio_input_conditioner.sv
// tb/tb_pio_input_conditioner.sv - randomized and directed bench for pio_input_conditioner against a sample-history model
module tb_pio_input_conditioner;

    localparam int P = 4;
    localparam int S = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] raw_in = 8'h00;
    logic       enable = 1'b1;
    logic [7:0] clean_out;
    logic       change;
    logic       sample_tick;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pio_input_conditioner #(
        .WIDTH(8), .PRESCALE(P), .STABLE_COUNT(S), .RESET_VALUE(8'h00)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .enable(enable),
        .clean_out(clean_out), .change(change), .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    // Model: raw delayed two edges; each bit keeps the last S tick samples taken
    // since its last acceptance and accepts when all of them oppose clean.
    logic [7:0] m_d1 = 8'h00, m_d2 = 8'h00, m_clean = 8'h00, m_acc;
    logic       m_change = 1'b0;
    int         m_en_cycles = 0;
    bit         m_hist [8][$];
    bit         m_all;
    logic       exp_tick;

    assign exp_tick = enable && ((m_en_cycles % P) == P - 1);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_d1 = 8'h00; m_d2 = 8'h00; m_clean = 8'h00; m_change = 1'b0; m_en_cycles = 0;
            for (int i = 0; i < 8; i++) m_hist[i].delete();
        end else begin
            m_acc = 8'h00;
            if (enable && ((m_en_cycles % P) == P - 1)) begin
                for (int i = 0; i < 8; i++) begin
                    m_hist[i].push_back(m_d2[i]);
                    if (m_hist[i].size() > S) void'(m_hist[i].pop_front());
                    if (m_hist[i].size() == S) begin
                        m_all = 1'b1;
                        for (int j = 0; j < S; j++) if (m_hist[i][j] == m_clean[i]) m_all = 1'b0;
                        m_acc[i] = m_all;
                    end
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (m_acc[i]) m_clean[i] = ~m_clean[i];
                if (m_acc[i] || !enable) m_hist[i].delete();
            end
            m_change = |m_acc;
            m_d2 = m_d1;
            m_d1 = raw_in;
            m_en_cycles = enable ? m_en_cycles + 1 : 0;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; raw_in = 8'h00;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (clean_out !== 8'h00 || change !== 1'b0)
            $display("FAIL reset_state clean=%h change=%b required clean=00 change=0", clean_out, change);
        else pass_cnt++;
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            total_cnt++;
            if (sample_tick !== (c % 4 == 3) || clean_out !== 8'h00 || change !== 1'b0)
                $display("FAIL reset_ticks cyc=%0d tick=%b clean=%h change=%b required tick=%b clean=00 change=0",
                         c, sample_tick, clean_out, change, (c % 4 == 3));
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        int lat = 0;
        int pulses = 0;
        raw_in = 8'h01;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            total_cnt++;
            if (clean_out !== m_clean || change !== m_change || sample_tick !== exp_tick)
                $display("FAIL model_single n=%0d clean=%h/%h change=%b/%b tick=%b/%b",
                         n, clean_out, m_clean, change, m_change, sample_tick, exp_tick);
            else pass_cnt++;
            if (change) pulses++;
            if (lat == 0 && clean_out[0]) lat = n;
        end
        total_cnt++;
        if (lat == 0 || lat > 2 + S * P + 1)
            $display("FAIL single_latency got=%0d required 1..%0d", lat, 2 + S * P + 1);
        else pass_cnt++;
        total_cnt++;
        if (pulses != 1 || clean_out !== 8'h01)
            $display("FAIL single_pulse pulses=%0d clean=%h required pulses=1 clean=01", pulses, clean_out);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int pulses = 0;
        raw_in = 8'h09;
        for (int n = 0; n < 35; n++) begin
            @(negedge clk);
            if (n == 4) raw_in = 8'h01;
            total_cnt++;
            if (clean_out !== m_clean || change !== m_change || sample_tick !== exp_tick)
                $display("FAIL model_glitch n=%0d clean=%h/%h change=%b/%b tick=%b/%b",
                         n, clean_out, m_clean, change, m_change, sample_tick, exp_tick);
            else pass_cnt++;
            if (change) pulses++;
        end
        total_cnt++;
        if (pulses != 0 || clean_out !== 8'h01 || dut.cnt[3] !== '0)
            $display("FAIL glitch pulses=%0d clean=%h cnt3=%0d required pulses=0 clean=01 cnt3=0",
                     pulses, clean_out, dut.cnt[3]);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        int pulses_bounce = 0;
        int pulses_hold = 0;
        for (int n = 0; n < 70; n++) begin
            if (n < 40) raw_in[7] = ((n / 3) % 2 == 0);
            else raw_in[7] = 1'b1;
            @(negedge clk);
            total_cnt++;
            if (clean_out !== m_clean || change !== m_change || sample_tick !== exp_tick)
                $display("FAIL model_bounce n=%0d clean=%h/%h change=%b/%b tick=%b/%b",
                         n, clean_out, m_clean, change, m_change, sample_tick, exp_tick);
            else pass_cnt++;
            if (change && n < 42) pulses_bounce++;
            if (change && n >= 42) pulses_hold++;
        end
        total_cnt++;
        if (pulses_bounce != 0 || pulses_hold != 1 || clean_out !== 8'h81)
            $display("FAIL bounce during=%0d after=%0d clean=%h required during=0 after=1 clean=81",
                     pulses_bounce, pulses_hold, clean_out);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] pat [3] = '{8'h00, 8'hFF, 8'h0F};
        logic [7:0] prev;
        for (int k = 0; k < 3; k++) begin
            int pulses = 0;
            prev = clean_out;
            raw_in = pat[k];
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                total_cnt++;
                if (clean_out !== m_clean || change !== m_change || (clean_out !== prev && clean_out !== pat[k]))
                    $display("FAIL model_simul k=%0d n=%0d clean=%h/%h change=%b/%b",
                             k, n, clean_out, m_clean, change, m_change);
                else pass_cnt++;
                if (change) pulses++;
            end
            total_cnt++;
            if (pulses != 1 || clean_out !== pat[k])
                $display("FAIL simul_step k=%0d pulses=%0d clean=%h required pulses=1 clean=%h",
                         k, pulses, clean_out, pat[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_enable();
        int ticks = 0;
        int n = 0;
        while (!sample_tick && n < 8) begin @(negedge clk); n++; end
        total_cnt++;
        if (!sample_tick) $display("FAIL enable_align tick=%b required 1", sample_tick);
        else pass_cnt++;
        raw_in = 8'h00;
        repeat (9) @(negedge clk);
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total_cnt++;
            if (clean_out !== 8'h0F || change !== 1'b0 || sample_tick !== 1'b0)
                $display("FAIL enable_low c=%0d clean=%h change=%b tick=%b required clean=0f change=0 tick=0",
                         c, clean_out, change, sample_tick);
            else pass_cnt++;
        end
        @(negedge clk);
        enable = 1'b1;
        n = 0;
        while (!change && n < 30) begin
            if (sample_tick) ticks++;
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (!change || ticks != S || clean_out !== 8'h00)
            $display("FAIL enable_restart change=%b ticks=%0d clean=%h required change=1 ticks=%0d clean=00",
                     change, ticks, clean_out, S);
        else pass_cnt++;
    endtask

    task automatic test_reset_midcount();
        int ticks = 0;
        int n = 0;
        raw_in = 8'hAA;
        repeat (20) @(negedge clk);
        total_cnt++;
        if (clean_out !== 8'hAA) $display("FAIL rst_pre clean=%h required aa", clean_out);
        else pass_cnt++;
        while (!sample_tick && n < 8) begin @(negedge clk); n++; end
        raw_in = 8'h55;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if (clean_out !== 8'h00 || change !== 1'b0)
            $display("FAIL rst_async clean=%h change=%b required clean=00 change=0", clean_out, change);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (!change && n < 30) begin
            if (sample_tick) ticks++;
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (!change || ticks != S || clean_out !== 8'h55)
            $display("FAIL rst_restart change=%b ticks=%0d clean=%h required change=1 ticks=%0d clean=55",
                     change, ticks, clean_out, S);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int hold = 0;
        for (int n = 0; n < 1500; n++) begin
            if (hold == 0) begin
                raw_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (raw_in ^ (8'h01 << $urandom_range(0, 7)));
                hold = $urandom_range(1, 24);
            end
            hold--;
            if ($urandom_range(0, 79) == 0) enable = ~enable;
            @(negedge clk);
            total_cnt++;
            if (clean_out !== m_clean || change !== m_change || sample_tick !== exp_tick)
                $display("FAIL model_random n=%0d clean=%h/%h change=%b/%b tick=%b/%b",
                         n, clean_out, m_clean, change, m_change, sample_tick, exp_tick);
            else pass_cnt++;
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_enable();
        test_reset_midcount();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
